// File: rtl/row_receiver.sv
// Receiving end of the row-transfer link.
// Requests one row at a time with a single-cycle send pulse, collects the row
// MSB-first as WORD_W-bit words over a valid/ready bus, and hands the assembled
// row to the consumer over a valid/ready handshake. After NUM_ROWS rows it
// parks in FINISH with done high until the next start.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   start       begin a new image (honoured only in IDLE or FINISH)
//   word_in     incoming word from the transmitter
//   word_valid  word_in carries a valid word
//   word_ready  receiver accepts word_in this cycle
//   send        one-cycle request for the next row
//   row_out     assembled row, first word in the MSBs
//   row_valid   row_out complete and stable
//   row_ready   consumer takes row_out
//   row_index   index of the row being collected or held
//   done        all NUM_ROWS rows delivered
module row_receiver #(
  parameter  int unsigned ROW_W    = 480,
  parameter  int unsigned WORD_W   = 16,
  parameter  int unsigned NUM_ROWS = 30,
  localparam int unsigned WORDS    = ROW_W / WORD_W,
  localparam int unsigned IDX_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              send,
  output logic [ROW_W-1:0]  row_out,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [IDX_W-1:0]  row_index,
  output logic              done
);

  localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             send_q, send_d;
  logic             word_ready_q, word_ready_d;
  logic             row_valid_q, row_valid_d;
  logic             done_q, done_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      row_q        <= '0;
      send_q       <= 1'b0;
      word_ready_q <= 1'b0;
      row_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      row_q        <= row_d;
      send_q       <= send_d;
      word_ready_q <= word_ready_d;
      row_valid_q  <= row_valid_d;
      done_q       <= done_d;
    end
  end

  // Next-state, word capture and row-index sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    row_d   = row_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        cnt_d   = '0;
        state_d = S_COLLECT;
      end

      S_COLLECT: begin
        if (word_valid && word_ready_q) begin
          // Constant-index slices keep the write decoder a plain one-hot mux.
          for (int unsigned k = 0; k < WORDS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              row_d[ROW_W-1-k*WORD_W -: WORD_W] = word_in;
            end
          end
          if (cnt_q == CNT_W'(WORDS - 1)) begin
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_HOLD: begin
        if (row_ready) begin
          if (idx_q == IDX_W'(NUM_ROWS - 1)) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_REQ;
          end
        end
      end

      S_FINISH: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of the state being entered, so each one
    // is high for exactly the cycles spent in its state.
    send_d       = (state_d == S_REQ);
    word_ready_d = (state_d == S_COLLECT);
    row_valid_d  = (state_d == S_HOLD);
    done_d       = (state_d == S_FINISH);
  end

  assign word_ready = word_ready_q;
  assign send       = send_q;
  assign row_out    = row_q;
  assign row_valid  = row_valid_q;
  assign row_index  = idx_q;
  assign done       = done_q;

endmodule

// File: tb/tb_row_receiver.sv
// Directed bench for row_receiver: expected rows are queued as each row is
// streamed in and checked against row_out when the consumer handshake fires.
module tb_row_receiver;

  localparam int unsigned ROW_W    = 480;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned NUM_ROWS = 30;
  localparam int unsigned WORDS    = 30;

  typedef struct {
    logic [ROW_W-1:0] row;
    logic [4:0]       idx;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              send;
  logic [ROW_W-1:0]  row_out;
  logic              row_valid;
  logic              row_ready;
  logic [4:0]        row_index;
  logic              done;

  exp_t        sb[$];
  int unsigned errors;
  int unsigned checks;
  int unsigned send_cnt;
  int unsigned base;
  logic        acc;

  row_receiver #(
    .ROW_W   (ROW_W),
    .WORD_W  (WORD_W),
    .NUM_ROWS(NUM_ROWS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .word_in   (word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .send      (send),
    .row_out   (row_out),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_index (row_index),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: settle handshakes seen before the edge, then sample 1 time unit after it.
  task automatic tick();
    logic hs;
    logic ac;
    exp_t e;
    hs = row_valid && row_ready;
    ac = word_valid && word_ready;
    if (hs) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 480'(1), 480'(0));
      end else begin
        e = sb.pop_front();
        check("row_out", row_out, e.row);
        check("row_index_hs", 480'(row_index), 480'(e.idx));
      end
    end
    @(posedge clk);
    #1;
    acc = ac;
    if (send === 1'b1) send_cnt++;
  endtask

  function automatic logic [ROW_W-1:0] mk_row(input int unsigned mode);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      case (mode)
        0:       r[ROW_W-1-k*WORD_W -: WORD_W] = 16'(k + 1);
        1:       r[ROW_W-1-k*WORD_W -: WORD_W] = 16'(16'h0100 + k);
        default: r[ROW_W-1-k*WORD_W -: WORD_W] = 16'($urandom);
      endcase
    end
    return r;
  endfunction

  // mode: 0 = valid every cycle, 1 = valid toggling, 2 = random valid.
  task automatic collect_row(input logic [ROW_W-1:0] row, input int unsigned mode,
                             input int unsigned idx, input logic pulse_start);
    int unsigned k;
    int unsigned budget;
    logic        ph;
    exp_t        e;
    k      = 0;
    budget = 0;
    ph     = 1'b1;
    e.row  = row;
    e.idx  = 5'(idx);
    sb.push_back(e);
    while (k < WORDS && budget < 1000) begin
      case (mode)
        0:       word_valid = 1'b1;
        1:       word_valid = ph;
        default: word_valid = ($urandom_range(0, 3) != 0);
      endcase
      ph      = ~ph;
      word_in = row[ROW_W-1-k*WORD_W -: WORD_W];
      start   = pulse_start && (k >= 5) && (k < 8);
      check("row_valid_early", 480'(row_valid && (k > 0)), 480'(0));
      tick();
      budget++;
      if (acc) k++;
    end
    start      = 1'b0;
    word_valid = 1'b0;
    if (k < WORDS) check("collect_timeout", 480'(k), 480'(WORDS));
  endtask

  initial begin
    logic [ROW_W-1:0] row_a;
    logic [ROW_W-1:0] row_b;
    logic [ROW_W-1:0] row_c;
    logic [ROW_W-1:0] r;
    int unsigned      k;
    int unsigned      budget;
    int unsigned      snap;

    errors = 0; checks = 0; send_cnt = 0; base = 0; acc = 1'b0;
    rst = 1'b0; start = 1'b0; word_in = '0; word_valid = 1'b0; row_ready = 1'b0;

    // Reset values.
    #1;
    check("rst_send", 480'(send), 480'(0));
    check("rst_word_ready", 480'(word_ready), 480'(0));
    check("rst_row_valid", 480'(row_valid), 480'(0));
    check("rst_done", 480'(done), 480'(0));
    check("rst_row_out", row_out, 480'(0));
    check("rst_row_index", 480'(row_index), 480'(0));
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("idle_no_send", 480'(send_cnt), 480'(0));
    check("idle_word_ready", 480'(word_ready), 480'(0));

    // Reset mid-COLLECT after 10 words.
    row_a = mk_row(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0; budget = 0;
    while (k < 10 && budget < 100) begin
      word_valid = 1'b1;
      word_in    = row_a[ROW_W-1-k*WORD_W -: WORD_W];
      tick();
      budget++;
      if (acc) k++;
    end
    if (k < 10) check("partial_timeout", 480'(k), 480'(10));
    check("partial_word_ready", 480'(word_ready), 480'(1));
    rst = 1'b0;
    #1;
    check("arst_send", 480'(send), 480'(0));
    check("arst_word_ready", 480'(word_ready), 480'(0));
    check("arst_row_valid", 480'(row_valid), 480'(0));
    check("arst_done", 480'(done), 480'(0));
    check("arst_row_out", row_out, 480'(0));
    check("arst_row_index", 480'(row_index), 480'(0));
    #2;
    rst  = 1'b1;
    snap = send_cnt;
    for (int i = 0; i < 10; i++) tick();
    word_valid = 1'b0;
    check("post_rst_no_send", 480'(send_cnt), 480'(snap));
    check("post_rst_word_ready", 480'(word_ready), 480'(0));

    // Row 0: steady stream, consumer always ready.
    row_ready = 1'b1;
    base  = send_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("send_after_start", 480'(send), 480'(1));
    check("row_index_start", 480'(row_index), 480'(0));
    collect_row(row_a, 0, 0, 1'b0);
    check("row_valid_latency", 480'(row_valid), 480'(1));
    r = row_out;
    check("row0_msb_word", 480'(r[479:464]), 480'(16'h0001));
    check("row0_lsb_word", 480'(r[15:0]), 480'(16'h001E));
    check("one_send_row0", 480'(send_cnt - base), 480'(1));

    // Row 1: same data, word_valid toggling.
    collect_row(row_a, 1, 1, 1'b0);
    check("sends_row1", 480'(send_cnt - base), 480'(2));

    // Row 2: consumer stalls 20 cycles while junk words are offered.
    tick();
    row_ready = 1'b0;
    row_b = mk_row(1);
    collect_row(row_b, 0, 2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      word_valid = 1'b1;
      word_in    = 16'($urandom);
      tick();
      check("stall_row_out", row_out, row_b);
      check("stall_word_ready", 480'(word_ready), 480'(0));
      check("stall_row_valid", 480'(row_valid), 480'(1));
    end
    word_valid = 1'b0;
    check("stall_no_send", 480'(send_cnt - base), 480'(3));
    row_ready = 1'b1;
    tick();
    check("send_after_release", 480'(send), 480'(1));
    check("row_index_3", 480'(row_index), 480'(3));

    // Row 3: start pulsed during COLLECT and during HOLD.
    row_ready = 1'b0;
    row_c = mk_row(2);
    collect_row(row_c, 2, 3, 1'b1);
    start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    start = 1'b0;
    check("start_ignored_idx", 480'(row_index), 480'(3));
    check("start_ignored_send", 480'(send_cnt - base), 480'(4));
    check("start_ignored_hold", 480'(row_valid), 480'(1));
    row_ready = 1'b1;

    // Rows 4..29 with random data and random valid gaps.
    for (int unsigned i = 4; i < NUM_ROWS; i++) begin
      row_c = mk_row(2);
      collect_row(row_c, 2, i, 1'b0);
    end
    tick();
    check("done_set", 480'(done), 480'(1));
    check("image_sends", 480'(send_cnt - base), 480'(NUM_ROWS));
    check("final_row_index", 480'(row_index), 480'(NUM_ROWS - 1));
    check("sb_drained", 480'(sb.size()), 480'(0));
    for (int i = 0; i < 50; i++) begin
      word_valid = 1'b1;
      tick();
      check("finish_done", 480'(done), 480'(1));
      check("finish_row_out", row_out, row_c);
      check("finish_word_ready", 480'(word_ready), 480'(0));
    end
    word_valid = 1'b0;
    check("finish_no_send", 480'(send_cnt - base), 480'(NUM_ROWS));

    // Restart from FINISH.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done", 480'(done), 480'(0));
    check("restart_idx", 480'(row_index), 480'(0));
    check("restart_send", 480'(send), 480'(1));
    tick();
    check("restart_send_pulse", 480'(send), 480'(0));
    check("restart_word_ready", 480'(word_ready), 480'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/row_receiver.md
Name: row_receiver

Overview:
- Receiving end of the row-transfer link driven by the row sender.
- Pulses `send` to request one image row from the transmitter.
- Collects the row as WORD_W-bit words over a valid/ready word bus and reassembles it into a ROW_W-bit row register.
- Presents the completed row to the CNN datapath with a valid/ready handshake, and asserts `done` after NUM_ROWS rows.

Parameters:
- ROW_W, 480, width of one image row in bits; must be an integer multiple of WORD_W.
- WORD_W, 16, width of one transfer word (one pixel).
- NUM_ROWS, 30, rows per image.
- WORDS = ROW_W/WORD_W (30), derived; not overridable.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin receiving a new image; sampled only in IDLE or FINISH.
- word_in  in  WORD_W  incoming word from transmitter.
- word_valid  in  1  word_in holds a valid word.
- word_ready  out  1  receiver accepts word_in this cycle.
- send  out  1  one-cycle pulse requesting the next row.
- row_out  out  ROW_W  assembled row.
- row_valid  out  1  row_out complete and stable.
- row_ready  in  1  consumer takes row_out.
- row_index  out  clog2(NUM_ROWS)  index of the row currently being collected or held.
- done  out  1  all NUM_ROWS rows delivered.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - send, word_ready, row_valid and done are 0.
  - row_out, row_index and the word counter are 0.
  - Reset mid-row discards partial data; no send is issued until the next start.
- IDLE: word_ready=0. When start=1, clear row_index, go to REQ.
- REQ (exactly one cycle):
  - send=1; word counter cleared.
  - Next state is COLLECT.
- COLLECT:
  - word_ready=1.
  - A word is accepted when word_valid && word_ready. Word k (k=0..WORDS-1) is written to row_out[ROW_W-1-k*WORD_W -: WORD_W], so the first word lands in the MSBs, matching the sender's MSB-first row order.
  - No acceptance means nothing changes; stalls of any length are allowed.
  - On acceptance of word WORDS-1, go to HOLD. row_valid=1 from the next cycle, giving 1-cycle latency from the last word to row_valid.
- HOLD:
  - row_valid=1, word_ready=0; row_out stable.
  - word_valid is ignored, and words offered in this state are not consumed.
  - On row_ready=1, row_valid drops next cycle.
    - If row_index==NUM_ROWS-1, go to FINISH.
    - Otherwise row_index+1 and go to REQ.
  - row_ready while row_valid=0 is ignored.
- FINISH:
  - done=1 held; word_ready=0; row_out retains the last row.
  - When start=1, clear done and row_index the following cycle and go to REQ. The IDLE step is skipped.
- start outside IDLE/FINISH is ignored.
- send is never asserted while row_valid=1; at most one send per row.
- Minimum time per row is 1 (REQ) + WORDS (COLLECT) + 1 (HOLD) cycles with no stalls, i.e. 32 cycles at default parameters.
- row_index never exceeds NUM_ROWS-1 and never wraps within an image.

Test Plan:
- Reset with rst=0 mid-COLLECT after 10 words → all outputs 0 immediately (asynchronously); after release, no send pulse until start.
- start, then 30 words 0x0001..0x001E each with word_valid=1, row_ready tied 1:
  - send pulses exactly once, 1 cycle after start.
  - row_out[479:464]=0x0001 and row_out[15:0]=0x001E.
  - row_valid high 1 cycle after the 30th word.
- Same stream but word_valid toggling 1,0,1,0 → identical row_out; the word counter advances only on accepted words.
- row_ready held 0 for 20 cycles after row_valid, with word_valid=1 and junk words offered:
  - row_out unchanged, word_ready=0, no second send.
  - After row_ready=1, send pulses on the next row request.
- Full image of 30 rows:
  - row_index goes 0..29, with exactly 30 send pulses.
  - done=1 after the 30th row_ready, held stable for 50 cycles.
  - A start in FINISH clears done and issues one send with row_index=0.
- start pulsed during COLLECT and during HOLD → no effect on the state, row_index or send count.
